// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the regfile_sb register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    function automatic int calc_aw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register pending-write bits with set-over-clear priority,
//               a clear-all input and two combinational busy lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREG     = NREG_DEF,
    parameter int  ZERO_REG = 1,
    localparam int AW       = calc_aw(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr_all,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_look_addr_1,
    input  logic [AW-1:0] i_look_addr_2,
    output logic          o_busy_1,
    output logic          o_busy_2
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;

    // A younger issue to the same register outranks the completing write.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en) w_pending_nxt[i_clr_addr] = 1'b0;
        if (i_set_en) w_pending_nxt[i_set_addr] = 1'b1;
        if (ZERO_REG != 0) w_pending_nxt[0] = 1'b0;
        if (i_clr_all) w_pending_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pending <= '0;
        else       r_pending <= w_pending_nxt;
    end

    assign o_busy_1 = r_pending[i_look_addr_1];
    assign o_busy_2 = r_pending[i_look_addr_2];

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Two-read/one-write register file with clear sweep and
//               pending-write scoreboard. Optional forwarding: REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEF,
    parameter int  NREG     = NREG_DEF,
    parameter int  ZERO_REG = 1,
    localparam int AW       = calc_aw(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_req,
    output logic            init_done,
    input  logic [AW-1:0]   rd_addr_1,
    input  logic [AW-1:0]   rd_addr_2,
    output logic [XLEN-1:0] rd_data_1,
    output logic [XLEN-1:0] rd_data_2,
    output logic            busy_1,
    output logic            busy_2,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr
);

    localparam logic [AW-1:0] c_last = AW'(NREG - 1);

    rf_state_t       r_state;
    logic [AW-1:0]   r_ptr;
    logic [XLEN-1:0] r_mem [NREG];

    logic            w_ready;
    logic            w_wr_commit;
    logic            w_sb_busy_1;
    logic            w_sb_busy_2;
    logic [XLEN-1:0] w_arr_1;
    logic [XLEN-1:0] w_arr_2;

    assign w_ready     = (r_state == RF_READY);
    assign w_wr_commit = w_ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign init_done   = w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RF_CLEAR;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    if (clr_req) begin
                        r_ptr <= '0;
                    end else if (r_ptr == c_last) begin
                        r_state <= RF_READY;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                RF_READY: begin
                    if (clr_req) begin
                        r_state <= RF_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_state <= RF_CLEAR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // No reset on the array so it can map onto distributed RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (!w_ready)         r_mem[r_ptr]   <= '0;
        else if (w_wr_commit) r_mem[wr_addr] <= wr_data;
    end

    always_comb begin
        w_arr_1 = r_mem[rd_addr_1];
        w_arr_2 = r_mem[rd_addr_2];
        if (!w_ready || ((ZERO_REG != 0) && (rd_addr_1 == '0))) w_arr_1 = '0;
        if (!w_ready || ((ZERO_REG != 0) && (rd_addr_2 == '0))) w_arr_2 = '0;
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_clr_all     (!w_ready || clr_req),
        .i_set_en      (w_ready && issue_en),
        .i_set_addr    (issue_addr),
        .i_clr_en      (w_wr_commit),
        .i_clr_addr    (wr_addr),
        .i_look_addr_1 (rd_addr_1),
        .i_look_addr_2 (rd_addr_2),
        .o_busy_1      (w_sb_busy_1),
        .o_busy_2      (w_sb_busy_2)
    );

`ifdef REGFILE_BYPASS_EN
    logic w_fwd_1;
    logic w_fwd_2;
    logic w_reissue;

    assign w_fwd_1   = w_wr_commit && (rd_addr_1 == wr_addr);
    assign w_fwd_2   = w_wr_commit && (rd_addr_2 == wr_addr);
    assign w_reissue = issue_en && (issue_addr == wr_addr);

    assign rd_data_1 = w_fwd_1 ? wr_data : w_arr_1;
    assign rd_data_2 = w_fwd_2 ? wr_data : w_arr_2;
    assign busy_1    = (w_fwd_1 && !w_reissue) ? 1'b0 : w_sb_busy_1;
    assign busy_2    = (w_fwd_2 && !w_reissue) ? 1'b0 : w_sb_busy_2;
`else
    assign rd_data_1 = w_arr_1;
    assign rd_data_2 = w_arr_2;
    assign busy_1    = w_sb_busy_1;
    assign busy_2    = w_sb_busy_2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb (32x32 and 8x16 instances)
//               against an array/flag reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr_req = 1'b0;
    logic        init_done;
    logic [4:0]  rd_addr_1 = '0, rd_addr_2 = '0;
    logic [31:0] rd_data_1, rd_data_2;
    logic        busy_1, busy_2;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;

    logic        reset8 = 1'b1;
    logic        init_done8;
    logic [2:0]  rd_addr8 = '0;
    logic [15:0] rd_data8_1, rd_data8_2;
    logic        busy8_1, busy8_2;
    logic        wr_en8 = 1'b0;
    logic [2:0]  wr_addr8 = '0;
    logic [15:0] wr_data8 = '0;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents, pending flags, sweep cycles left.
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_ready;
    int          m_left;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .reset(reset), .clr_req(clr_req), .init_done(init_done),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .busy_1(busy_1), .busy_2(busy_2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    regfile_sb #(.XLEN(16), .NREG(8)) dut8 (
        .clk(clk), .reset(reset8), .clr_req(1'b0), .init_done(init_done8),
        .rd_addr_1(rd_addr8), .rd_addr_2(rd_addr8),
        .rd_data_1(rd_data8_1), .rd_data_2(rd_data8_2),
        .busy_1(busy8_1), .busy_2(busy8_2),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .issue_en(1'b0), .issue_addr(3'd0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_left  = 32;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endtask

    task automatic model_edge();
        if (reset) return;
        if (m_ready) begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
            if (clr_req) model_reset();
        end else begin
            m_left = clr_req ? 32 : m_left - 1;
            if (m_left == 0) begin
                m_ready = 1'b1;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!m_ready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr != 0 && a == wr_addr) return wr_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr != 0 && a == wr_addr && !(issue_en && issue_addr == wr_addr))
            return 1'b0;
`endif
        return m_pend[a];
    endfunction

    task automatic check_all(input string tag);
        #1;
        check({tag, ".rd1"},  rd_data_1, exp_rd(rd_addr_1));
        check({tag, ".rd2"},  rd_data_2, exp_rd(rd_addr_2));
        check({tag, ".busy1"}, {31'd0, busy_1}, {31'd0, exp_busy(rd_addr_1)});
        check({tag, ".busy2"}, {31'd0, busy_2}, {31'd0, exp_busy(rd_addr_2)});
        check({tag, ".init"}, {31'd0, init_done}, {31'd0, m_ready});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic sweep_count(output int n);
        n = 0;
        while (!init_done && n < 100) begin
            check_all("sweep");
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        model_reset();
        foreach (m_mem[i]) m_mem[i] = '0;
        check_all("reset");
        tick();
        tick();
        reset = 1'b0;

        // Sweep after reset; a write during it must be dropped.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr_1 = 5'd5;
        n = 0;
        while (!init_done && n < 100) begin
            check_all("sweep0");
            tick();
            n++;
            if (n == 2) wr_en = 1'b0;
        end
        check("sweep_len", n, 32);
        #1 check("r5_dropped", rd_data_1, 32'h0);
        for (int a = 0; a < 16; a++) begin
            rd_addr_1 = 5'(a); rd_addr_2 = 5'(31 - a);
            check_all("zero_scan");
            check("zero_rd1", rd_data_1, 32'h0);
            check("zero_rd2", rd_data_2, 32'h0);
            tick();
        end

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        tick();
        wr_en = 1'b0; rd_addr_1 = 5'd7; rd_addr_2 = 5'd7;
        check_all("r7");
        check("r7_p1", rd_data_1, 32'h12345678);
        check("r7_p2", rd_data_2, 32'h12345678);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 1'b0; rd_addr_1 = 5'd0;
        #1 check("r0_zero", rd_data_1, 32'h0);

        // Scoreboard: issue r3, write two cycles later, then same-cycle issue+write.
        issue_en = 1'b1; issue_addr = 5'd3; rd_addr_1 = 5'd3; rd_addr_2 = 5'd3;
        check_all("iss3");
        tick();
        issue_en = 1'b0;
        #1 check("busy3_c1", {31'd0, busy_1}, 32'd1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        #1 check("busy3_c2", {31'd0, busy_1}, 32'd0);
`else
        #1 check("busy3_c2", {31'd0, busy_1}, 32'd1);
`endif
        tick();
        wr_en = 1'b0;
        check_all("wr3");
        check("busy3_after", {31'd0, busy_1}, 32'd0);
        check("r3_data", rd_data_1, 32'hA5A5A5A5);
        issue_en = 1'b1; wr_en = 1'b1; wr_data = 32'h0000_0033;
        tick();
        issue_en = 1'b0; wr_en = 1'b0;
        check_all("iss_wr3");
        check("busy3_setwins", {31'd0, busy_1}, 32'd1);

        // Same-cycle read of the register being written.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
        tick();
        wr_data = 32'h2; rd_addr_1 = 5'd9; rd_addr_2 = 5'd9;
        check_all("fwd9");
`ifdef REGFILE_BYPASS_EN
        check("r9_same_p1", rd_data_1, 32'h2);
        check("r9_same_p2", rd_data_2, 32'h2);
`else
        check("r9_same_p1", rd_data_1, 32'h1);
        check("r9_same_p2", rd_data_2, 32'h1);
`endif
        tick();
        wr_en = 1'b0;
        #1 check("r9_next", rd_data_1, 32'h2);

        // Reset mid-sweep at ptr=10 restarts a full sweep.
        reset = 1'b1; model_reset();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_all("mid_sweep");
        reset = 1'b1; model_reset();
        check_all("mid_reset");
        tick();
        reset = 1'b0;
        sweep_count(n);
        check("resweep_len", n, 32);

        // clr_req in READY clears pending and re-runs the sweep.
        issue_en = 1'b1; issue_addr = 5'd4; rd_addr_1 = 5'd4;
        tick();
        issue_en = 1'b0;
        #1 check("busy4_set", {31'd0, busy_1}, 32'd1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0; issue_en = 1'b1;
        check_all("clr");
        check("clr_busy4", {31'd0, busy_1}, 32'd0);
        check("clr_init", {31'd0, init_done}, 32'd0);
        sweep_count(n);
        issue_en = 1'b0;
        check("clr_sweep_len", n, 32);
        #1 check("busy4_after_clr", {31'd0, busy_1}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 300; c++) begin
            wr_en      = ($urandom_range(1, 0) == 1);
            wr_addr    = 5'($urandom);
            wr_data    = $urandom;
            issue_en   = ($urandom_range(1, 0) == 1);
            issue_addr = ($urandom_range(3, 0) == 0) ? wr_addr : 5'($urandom);
            rd_addr_1  = ($urandom_range(1, 0) == 1) ? wr_addr : 5'($urandom);
            rd_addr_2  = ($urandom_range(1, 0) == 1) ? issue_addr : 5'($urandom);
            clr_req    = ($urandom_range(99, 0) == 0);
            check_all("rand");
            tick();
        end
        wr_en = 1'b0; issue_en = 1'b0; clr_req = 1'b0;

        // 8-entry, 16-bit instance.
        reset8 = 1'b0;
        n = 0;
        while (!init_done8 && n < 100) begin
            tick();
            n++;
        end
        check("sweep8_len", n, 8);
        wr_en8 = 1'b1; wr_addr8 = 3'd7; wr_data8 = 16'hBEEF;
        tick();
        wr_en8 = 1'b0; rd_addr8 = 3'd7;
        #1 check("r7_w16", {16'd0, rd_data8_1}, 32'h0000BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined CPU datapath.
- Successor to the single-cycle 32x32 register file; adds configurable width and depth, and a per-register pending-write scoreboard for hazard detection.
- Clears its array with a post-reset/soft-clear sweep (one entry per cycle), so it maps to distributed RAM instead of flops with a global reset.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, 2..64.
- AW, $clog2(NREG), address width; derived, not overridden.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clr_req  in  1  one-cycle pulse: restart the clear sweep
- init_done  out  1  high when the array is cleared and accepting writes
- rd_addr_1  in  AW  read port 1 address
- rd_addr_2  in  AW  read port 2 address
- rd_data_1  out  XLEN  read port 1 data
- rd_data_2  out  XLEN  read port 2 data
- busy_1  out  1  pending write outstanding on rd_addr_1
- busy_2  out  1  pending write outstanding on rd_addr_2
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback address
- wr_data  in  XLEN  writeback data
- issue_en  in  1  instruction issued that will write issue_addr
- issue_addr  in  AW  destination of the issued instruction

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to CLEAR with sweep pointer 0.
  - Pending bits all 0.
  - init_done=0, busy_1/2=0.
  - rd_data_1/2 read 0 for the whole sweep (forced, not read from the array).
- FSM states:
  - CLEAR: writes 0 to entry ptr each cycle and increments ptr. On ptr==NREG-1 it moves to READY at the next edge. The sweep takes exactly NREG cycles after reset deasserts. In CLEAR, wr_en and issue_en are ignored and pending bits are held at 0.
  - READY: init_done=1. clr_req returns the FSM to CLEAR with ptr=0 and clears all pending bits on the same edge.
  - clr_req during CLEAR restarts ptr at 0.
  - Reset asserted mid-sweep restarts the sweep after release.
- Reads:
  - Combinational from the array.
  - With ZERO_REG=1, address 0 returns 0 and busy=0 regardless of array or pending contents.
- Writes:
  - Commit at the rising edge when wr_en && READY && !(ZERO_REG && wr_addr==0).
  - Same-cycle read of the address being written returns the old value (no bypass; see Optional Feature).
- Scoreboard, one pending bit per register:
  - issue_en sets pending[issue_addr].
  - wr_en clears pending[wr_addr].
  - Same address, same cycle: set wins (the younger issue supersedes the completing write).
  - Different addresses: both take effect.
  - Issue to reg 0 with ZERO_REG=1 is ignored.
  - A write to a register that is not pending still commits data; the pending bit stays 0.
- busy_x = pending[rd_addr_x]; combinational, reflects state before the current edge.
- Width: data is stored and returned unmodified at XLEN bits. No sign handling.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-to-read forwarding):
  - If wr_en is valid (READY, non-zero reg) and rd_addr_x==wr_addr, then rd_data_x=wr_data in the same cycle.
  - busy_x is forced to 0 in that cycle unless issue_en && issue_addr==wr_addr in the same cycle.
  - Both ports forward independently.
- Undefined: reads return array contents only; busy_x reflects the pending bits unchanged.

Decomposition:
- Package regfile_pkg holds:
  - the state enum {RF_CLEAR, RF_READY}
  - the default XLEN/NREG constants
  - the AW derivation function
- One sub-module: regfile_scoreboard (pending bit vector, set/clear priority, clear-all input, two busy lookups).
- The array, FSM and forwarding stay in regfile_sb.

Test Plan:
- Release reset with NREG=32 → init_done=0 for exactly 32 cycles, then 1; every register reads 0x00000000; a wr_en during the sweep (r5 ← 0xDEADBEEF) is dropped and r5 reads 0.
- READY; write r7 ← 0x12345678, then read r7 on both ports → 0x12345678. Write r0 ← 0xFFFFFFFF → r0 reads 0.
- Issue r3, then wr_en r3 ← 0xA5A5A5A5 two cycles later → busy_1 (rd_addr_1=3) is 1 for those two cycles, 0 after the write edge. Same-cycle issue r3 + write r3 → busy stays 1.
- With REGFILE_BYPASS_EN: r9 holds 0x1, wr_en r9 ← 0x2, rd_addr_1=rd_addr_2=9 same cycle → both read 0x2. Without the macro → both read 0x1, then 0x2 next cycle.
- Assert reset mid-sweep at ptr=10, release → full 32-cycle sweep again. In READY, pulse clr_req with r4 pending → all pending bits 0, init_done falls for 32 cycles.
- Parameter point XLEN=16, NREG=8: write r7 ← 0xBEEF, read back 0xBEEF; sweep length is 8 cycles.
